fft_spectrum_sink: RTL and testbench
====================================

# fft_spectrum_sink

Receive-side companion to the FFT sample feeder: consumes the FFT core's output AXI4-stream (complex bins plus bin index), converts each bin to an approximate magnitude and writes it into a ping-pong spectrum buffer. A completed, length-checked frame is published atomically by a bank swap, so the display/readout logic always reads a whole, consistent spectrum. Sits between `fft_demo_00` output and the spectrum display path, on the `fft_clk` domain.

## Interface
- `N_POINTS`, 1024: FFT length; power of two, 8..4096.
- `DATA_W`, 16: width of each signed real/imag component.
- `ADDR_W`, $clog2(N_POINTS): bin index width.
- `MAG_W`, DATA_W+1: magnitude width, unsigned.

Ports:
- `clk`: input, 1 bit. FFT output clock; all logic is on its rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `en`: input, 1 bit. Capture enable.
- `s_tvalid`: input, 1 bit. FFT output beat valid. There is no backpressure; every valid beat is consumed.
- `s_tdata`: input, 2*DATA_W bits. {im, re}, both two's complement; re occupies the low half.
- `s_tlast`: input, 1 bit. Marks the last bin of a frame.
- `s_tuser`: input, ADDR_W bits. Bin index of the beat.
- `rd_addr`: input, ADDR_W bits. Display read address.
- `rd_data`: output, MAG_W bits. Magnitude from the published bank; registered.
- `bank_sel`: output, 1 bit. Index of the published (readable) bank.
- `frame_done`: output, 1 bit. One-cycle pulse when a frame is published.
- `frame_err`: output, 1 bit. One-cycle pulse when a frame is discarded.
- `frame_cnt`: output, 16 bits. Count of published frames; wraps.

## Operation
- States: IDLE, CAPTURE, SKIP, COMMIT.
- IDLE:
  - Ignores beats.
  - When `en`=1 and a valid beat arrives with `s_tuser`=0, that beat is captured as bin 0 and the state moves to CAPTURE. The beat counter is loaded with 1.
  - If that same beat also has `s_tlast`=1, it is treated as a short frame: `frame_err` pulses and the state returns to IDLE.
- CAPTURE:
  - Each valid beat enters the magnitude pipeline and the beat counter increments.
  - If `s_tlast`=1 and the count including this beat equals N_POINTS, go to COMMIT.
  - If `s_tlast`=1 and the count is less than N_POINTS, pulse `frame_err` and go to IDLE; no swap.
  - If the count reaches N_POINTS without `s_tlast`, pulse `frame_err` and go to SKIP.
- SKIP: discards beats up to and including the next `s_tlast`, then goes to IDLE.
- COMMIT:
  - Waits until the pipeline has drained (last write done).
  - Then toggles `bank_sel`, pulses `frame_done`, increments `frame_cnt` and goes to IDLE.
- `en`=0 in CAPTURE or SKIP aborts the frame: go to IDLE, no pulse, no swap. COMMIT always completes.
- Magnitude:
  - |x| is computed at width DATA_W+1, so |−2^(DATA_W−1)| is exact.
  - mag = max(|re|,|im|) + (min(|re|,|im|) >> 1), truncated toward zero. It cannot overflow MAG_W.
- The write address is `s_tuser`, not the counter. Duplicate indices overwrite; unwritten bins keep stale data.
- Writes always go to bank ~`bank_sel`; reads always come from bank `bank_sel`.

## Timing
- Reset values: `bank_sel`=0, `rd_data`=0, `frame_done`=0, `frame_err`=0, `frame_cnt`=0, state IDLE. RAM contents are not cleared.
- Magnitude pipeline, for a beat accepted at edge t:
  - abs registered at t.
  - magnitude registered at t+1.
  - RAM write at t+2.
- For an `s_tlast` beat at edge t, `frame_done` is high and `bank_sel` toggles in the cycle following edge t+3. `frame_err` is high in the cycle following edge t.
- Back-to-back frames: a beat with `s_tuser`=0 arriving while in COMMIT is not captured; that frame is skipped. The FFT core's inter-frame gap is at least 4 cycles, so this does not occur in normal operation.
- Read: `rd_data` is valid one cycle after `rd_addr`. The bank is selected by `bank_sel` at the edge where the address is sampled, so a read never mixes banks.

## Structure
- Shared package `scope_pkg`:
  - N_POINTS and DATA_W defaults.
  - State enum.
  - Magnitude function.
- Sub-module `spectrum_ram`:
  - Simple dual-port RAM, 2*N_POINTS × MAG_W.
  - One write port and one registered read port; address is {bank, bin}.
  - Inferable as block RAM.

## Test plan
- Clean frame, N_POINTS=8, bins re=k, im=−k for k=0..7: after the swap, reading addr 5 returns 7 (5+2). `bank_sel` goes 0→1, `frame_done` is one pulse, `frame_cnt`=1.
- Extreme values, re=−32768 and im=−32768: mag=49152. Re=32767, im=0: mag=32767.
- Short frame, `s_tlast` on beat 5 of 8: `frame_err` pulses the cycle after that beat, `bank_sel` is unchanged, the old spectrum is still readable.
- Long frame, 10 beats with `s_tlast` on beat 10: `frame_err` pulses at beat 8, beats 9 and 10 are ignored, the next frame starting at bin 0 is captured normally.
- Abort and mid-frame start:
  - `en` dropped at beat 3: no pulse, no swap.
  - `en` raised mid-frame (`s_tuser`=4): beats are ignored until the next `s_tuser`=0.
- `rst_n` asserted asynchronously during COMMIT: outputs return immediately to their reset values, no `frame_done`, and the next clean frame publishes to bank 1.

Source files
------------

// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// scope_pkg : shared defaults, capture FSM states and bin magnitude helper
// Rev 1.0
// ============================================================================
package scope_pkg;

  localparam int DEF_N_POINTS = 1024;
  localparam int DEF_DATA_W   = 16;
  // Working width of the magnitude helper; covers DATA_W up to 32.
  localparam int MAX_MAG_W    = 33;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SKIP    = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  // Alpha-max-plus-beta-min with alpha=1, beta=1/2, on already-absolute inputs.
  function automatic logic [MAX_MAG_W-1:0] mag_approx(
    input logic [MAX_MAG_W-1:0] a,
    input logic [MAX_MAG_W-1:0] b
  );
    logic [MAX_MAG_W-1:0] v_max;
    logic [MAX_MAG_W-1:0] v_min;
    if (a >= b) begin
      v_max = a;
      v_min = b;
    end else begin
      v_max = b;
      v_min = a;
    end
    return v_max + (v_min >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spectrum_ram.sv
`default_nettype none
// ============================================================================
// spectrum_ram : simple dual-port ping-pong spectrum store, {bank, bin} address
// Rev 1.0
// ============================================================================
module spectrum_ram #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int MAG_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [MAG_W-1:0]  wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [MAG_W-1:0]  rd_data
);

  logic [MAG_W-1:0] r_mem [0:2*N_POINTS-1];
  logic [MAG_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Output register carries the reset; the array itself is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_spectrum_sink.sv
`default_nettype none
// ============================================================================
// fft_spectrum_sink : FFT output stream -> magnitude -> ping-pong spectrum
// Rev 1.0
// ============================================================================
module fft_spectrum_sink
  import scope_pkg::*;
#(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = $clog2(N_POINTS),
  parameter int MAG_W    = DATA_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                s_tvalid,
  input  logic [2*DATA_W-1:0] s_tdata,
  input  logic                s_tlast,
  input  logic [ADDR_W-1:0]   s_tuser,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [MAG_W-1:0]    rd_data,
  output logic                bank_sel,
  output logic                frame_done,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
);

  localparam int                 c_cnt_w = ADDR_W + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(N_POINTS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [c_cnt_w-1:0]  w_cnt_inc;
  logic                w_accept;
  logic                w_err;
  logic                w_done;
  logic                w_drained;

  logic                r_bank_sel;
  logic                r_frame_done;
  logic                r_frame_err;
  logic [15:0]         r_frame_cnt;

  logic [DATA_W-1:0]   w_re;
  logic [DATA_W-1:0]   w_im;
  logic [MAG_W-1:0]    w_re_ext;
  logic [MAG_W-1:0]    w_im_ext;
  logic [MAG_W-1:0]    w_abs_re;
  logic [MAG_W-1:0]    w_abs_im;

  logic                r_s1_v;
  logic [MAG_W-1:0]    r_s1_abs_re;
  logic [MAG_W-1:0]    r_s1_abs_im;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic                r_s2_v;
  logic [MAG_W-1:0]    r_s2_mag;
  logic [ADDR_W-1:0]   r_s2_addr;

  // Sign-extend by one bit first so that the most negative value has an exact |x|.
  assign w_re     = s_tdata[DATA_W-1:0];
  assign w_im     = s_tdata[2*DATA_W-1:DATA_W];
  assign w_re_ext = {w_re[DATA_W-1], w_re};
  assign w_im_ext = {w_im[DATA_W-1], w_im};
  assign w_abs_re = w_re_ext[MAG_W-1] ? (MAG_W'(0) - w_re_ext) : w_re_ext;
  assign w_abs_im = w_im_ext[MAG_W-1] ? (MAG_W'(0) - w_im_ext) : w_im_ext;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_drained = !r_s1_v && !r_s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && s_tvalid && (s_tuser == '0)) begin
          w_accept  = 1'b1;
          w_cnt_nxt = c_cnt_w'(1);
          if (s_tlast) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (s_tvalid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (s_tlast) begin
            if (w_cnt_inc == c_full) begin
              w_state_nxt = ST_COMMIT;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else if (w_cnt_inc == c_full) begin
            w_err       = 1'b1;
            w_state_nxt = ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        if (!en || (s_tvalid && s_tlast)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        // Swap only after the final bin has landed in the RAM.
        if (w_drained) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_bank_sel   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
      if (w_done) begin
        r_bank_sel  <= ~r_bank_sel;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_abs_re <= '0;
      r_s1_abs_im <= '0;
      r_s1_addr   <= '0;
      r_s2_v      <= 1'b0;
      r_s2_mag    <= '0;
      r_s2_addr   <= '0;
    end else begin
      r_s1_v      <= w_accept;
      r_s1_abs_re <= w_abs_re;
      r_s1_abs_im <= w_abs_im;
      r_s1_addr   <= s_tuser;
      r_s2_v      <= r_s1_v;
      r_s2_mag    <= MAG_W'(mag_approx(MAX_MAG_W'(r_s1_abs_re), MAX_MAG_W'(r_s1_abs_im)));
      r_s2_addr   <= r_s1_addr;
    end
  end

  spectrum_ram #(
    .N_POINTS (N_POINTS),
    .ADDR_W   (ADDR_W),
    .MAG_W    (MAG_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (r_s2_v),
    .wr_addr ({~r_bank_sel, r_s2_addr}),
    .wr_data (r_s2_mag),
    .rd_addr ({r_bank_sel, rd_addr}),
    .rd_data (rd_data)
  );

  assign bank_sel   = r_bank_sel;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_spectrum_sink.sv
`default_nettype none
// ============================================================================
// tb_fft_spectrum_sink : directed table-driven bench for fft_spectrum_sink (N=8)
// Rev 1.0
// ============================================================================
module tb_fft_spectrum_sink;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int MW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          s_tvalid;
  logic [2*DW-1:0] s_tdata;
  logic          s_tlast;
  logic [AW-1:0] s_tuser;
  logic [AW-1:0] rd_addr;
  logic [MW-1:0] rd_data;
  logic          bank_sel;
  logic          frame_done;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [MW-1:0]        mag;
  } vec_t;

  vec_t tbl [16];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = -1;
  int err_cyc = -1;

  fft_spectrum_sink #(
    .N_POINTS (N),
    .DATA_W   (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .bank_sel   (bank_sel),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (frame_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int re, input int im, input int mag);
    tbl[i].re  = DW'(re);
    tbl[i].im  = DW'(im);
    tbl[i].mag = MW'(mag);
  endtask

  task automatic beat(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                      input int idx, input logic last, output int e_no);
    s_tvalid = 1'b1;
    s_tdata  = {im, re};
    s_tuser  = AW'(idx);
    s_tlast  = last;
    @(negedge clk);
    e_no     = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_tbl(input int base, output int t_last);
    int t;
    for (int k = 0; k < N; k++) begin
      beat(tbl[base+k].re, tbl[base+k].im, k, k == N-1, t);
    end
    t_last = t;
  endtask

  task automatic check_read(input int addr, input logic [MW-1:0] exp, input string name);
    rd_addr = AW'(addr);
    @(negedge clk);
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_bank(input int base, input string tag);
    for (int k = 0; k < N; k++) begin
      check_read(k, tbl[base+k].mag, $sformatf("%s_bin%0d", tag, k));
    end
  endtask

  initial begin
    int t;
    int t8;
    int d0;
    int e0;

    // Frame A: re=k, im=-k -> k + floor(k/2)
    set_vec(0, 0,  0,  0);
    set_vec(1, 1, -1,  1);
    set_vec(2, 2, -2,  3);
    set_vec(3, 3, -3,  4);
    set_vec(4, 4, -4,  6);
    set_vec(5, 5, -5,  7);
    set_vec(6, 6, -6,  9);
    set_vec(7, 7, -7, 10);
    // Frame B: extremes and mixed signs
    set_vec(8,  -32768, -32768, 49152);
    set_vec(9,   32767,      0, 32767);
    set_vec(10,      0, -32768, 32768);
    set_vec(11,     -3,     10,    11);
    set_vec(12,    100,   -101,   151);
    set_vec(13,     -1,     -1,     1);
    set_vec(14,  32767, -32768, 49151);
    set_vec(15,      7,      7,    10);

    rst_n = 1'b0; en = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tuser = '0; rd_addr = '0;
    idle(3);
    chk("rst_bank_sel",   32'(bank_sel),   0);
    chk("rst_rd_data",    32'(rd_data),    0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_err",  32'(frame_err),  0);
    chk("rst_frame_cnt",  32'(frame_cnt),  0);
    rst_n = 1'b1;
    idle(2);

    // Clean frame A
    en = 1'b1;
    d0 = done_cnt;
    send_tbl(0, t);
    idle(6);
    chk("A_done_pulses", 32'(done_cnt - d0), 1);
    chk("A_done_cycle",  32'(done_cyc), 32'(t + 3));
    chk("A_no_err",      32'(err_cnt), 0);
    chk("A_bank_sel",    32'(bank_sel), 1);
    chk("A_frame_cnt",   32'(frame_cnt), 1);
    check_bank(0, "A");

    // Frame B publishes into the other bank
    send_tbl(8, t);
    idle(6);
    chk("B_done_cycle", 32'(done_cyc), 32'(t + 3));
    chk("B_bank_sel",   32'(bank_sel), 0);
    chk("B_frame_cnt",  32'(frame_cnt), 2);
    check_bank(8, "B");

    // Short frame: tlast on beat 5
    e0 = err_cnt; d0 = done_cnt;
    for (int k = 0; k < 5; k++) beat(16'sd1000, 16'sd0, k, k == 4, t);
    idle(6);
    chk("short_err_pulses", 32'(err_cnt - e0), 1);
    chk("short_err_cycle",  32'(err_cyc), 32'(t));
    chk("short_no_done",    32'(done_cnt - d0), 0);
    chk("short_bank_sel",   32'(bank_sel), 0);
    check_read(3, 17'd11, "short_old_spectrum");

    // Long frame: 10 beats, tlast on beat 10
    e0 = err_cnt; d0 = done_cnt; t8 = 0;
    for (int k = 0; k < 10; k++) begin
      beat(16'sd500, 16'sd500, k % N, k == 9, t);
      if (k == 7) t8 = t;
    end
    idle(6);
    chk("long_err_pulses", 32'(err_cnt - e0), 1);
    chk("long_err_cycle",  32'(err_cyc), 32'(t8));
    chk("long_no_done",    32'(done_cnt - d0), 0);
    chk("long_bank_sel",   32'(bank_sel), 0);
    send_tbl(0, t);
    idle(6);
    chk("after_long_done_cycle", 32'(done_cyc), 32'(t + 3));
    chk("after_long_bank_sel",   32'(bank_sel), 1);
    chk("after_long_frame_cnt",  32'(frame_cnt), 3);
    check_read(5, 17'd7, "after_long_bin5");
    check_read(0, 17'd0, "after_long_bin0");

    // Abort at beat 3, then enable mid-frame at bin 4
    e0 = err_cnt; d0 = done_cnt;
    for (int k = 0; k < N; k++) begin
      if (k == 3) en = 1'b0;
      beat(tbl[8+k].re, tbl[8+k].im, k, k == N-1, t);
    end
    idle(4);
    en = 1'b1;
    for (int k = 4; k < N; k++) beat(16'sd200, 16'sd200, k, k == N-1, t);
    idle(6);
    chk("abort_no_err",    32'(err_cnt - e0), 0);
    chk("abort_no_done",   32'(done_cnt - d0), 0);
    chk("abort_bank_sel",  32'(bank_sel), 1);
    chk("abort_frame_cnt", 32'(frame_cnt), 3);
    send_tbl(8, t);
    idle(6);
    chk("resume_bank_sel",  32'(bank_sel), 0);
    chk("resume_frame_cnt", 32'(frame_cnt), 4);
    check_read(0, 17'd49152, "resume_bin0");
    check_read(6, 17'd49151, "resume_bin6");

    // Asynchronous reset while in COMMIT
    d0 = done_cnt;
    send_tbl(0, t);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_frame_cnt",  32'(frame_cnt), 0);
    chk("arst_rd_data",    32'(rd_data), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    chk("arst_bank_sel",   32'(bank_sel), 0);
    idle(5);
    chk("arst_no_done", 32'(done_cnt - d0), 0);
    rst_n = 1'b1;
    idle(2);
    send_tbl(0, t);
    idle(6);
    chk("post_rst_done_cycle", 32'(done_cyc), 32'(t + 3));
    chk("post_rst_bank_sel",   32'(bank_sel), 1);
    chk("post_rst_frame_cnt",  32'(frame_cnt), 1);
    check_read(5, 17'd7, "post_rst_bin5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
